fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/cpu_pkg.sv | 23 ++
 rtl/fetch_queue.sv | 80 ++++++++
 rtl/fetch_stage.sv | 118 +++++++++++
 tb/tb_fetch_stage.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared front-end types: fetch FSM encoding, fetch queue entry layout, default reset PC.
// No logic of its own; imported by fetch_stage and fetch_queue.
// Backpressure: n/a.
package cpu_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH_REQ  = 2'd0,
        FETCH_WAIT = 2'd1,
        FETCH_DROP = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Fetch queue: DEPTH x {pc, instr} FIFO with push, pop and single-cycle flush.
// Latency: pushed entry visible at head the cycle after push; flush wins over push/pop.
// Backpressure: push ignored when full, pop ignored when empty; owner gates via count/full/empty.
module fetch_queue
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  fetch_entry_t                 push_dat,
    input  logic                         pop,
    input  logic                         flush,
    output fetch_entry_t                 head_dat,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    fetch_entry_t   mem_q [DEPTH];
    fetch_entry_t   mem_d [DEPTH];
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           push_ok, pop_ok;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign head_dat = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        push_ok  = push && !full;
        pop_ok   = pop && !empty;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                mem_d[wr_ptr_q] = push_dat;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            // Simultaneous push and pop leave the occupancy unchanged.
            if (push_ok && !pop_ok) begin
                count_d = count_q + 1'b1;
            end else if (pop_ok && !push_ok) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: one outstanding imem request, QDEPTH-entry queue towards decode, redirect flush.
// Latency: imem_rvalid to dec_valid 1 cycle; 0 cycles on an empty queue when FETCH_BYPASS_EN is defined.
// Backpressure: dec_ready low fills the queue; imem_req drops once queued + outstanding reaches QDEPTH.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        dec_ready,
    output logic        dec_valid,
    output logic [31:0] dec_pc,
    output logic [31:0] dec_instruction
);

    localparam int            CW       = $clog2(QDEPTH + 1);
    localparam logic [CW-1:0] QDEPTH_C = CW'(QDEPTH);

    fetch_state_e  state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   req_pc_q, req_pc_d;

    logic          q_push, q_pop, q_flush, q_full, q_empty;
    logic [CW-1:0] q_count;
    fetch_entry_t  q_head, rsp_entry;
    logic          rsp_take;

    fetch_queue #(
        .DEPTH    (QDEPTH)
    ) u_queue (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (q_push),
        .push_dat (rsp_entry),
        .pop      (q_pop),
        .flush    (q_flush),
        .head_dat (q_head),
        .count    (q_count),
        .full     (q_full),
        .empty    (q_empty)
    );

    always_comb begin
        state_d         = state_q;
        fetch_pc_d      = fetch_pc_q;
        req_pc_d        = req_pc_q;
        // Only REQ can issue, so the outstanding count is zero whenever this is evaluated.
        imem_req        = rst_n && (state_q == FETCH_REQ) && (q_count < QDEPTH_C);
        imem_addr       = fetch_pc_q;
        rsp_take        = (state_q == FETCH_WAIT) && imem_rvalid && !redirect_valid;
        rsp_entry.pc    = req_pc_q;
        rsp_entry.instr = imem_rdata;
        dec_valid       = !q_empty && !redirect_valid;
        dec_pc          = q_head.pc;
        dec_instruction = q_head.instr;
        q_push          = rsp_take && !q_full;
`ifdef FETCH_BYPASS_EN
        if (q_empty && rsp_take) begin
            dec_valid       = 1'b1;
            dec_pc          = req_pc_q;
            dec_instruction = imem_rdata;
            q_push          = !dec_ready;
        end
`endif
        q_pop   = dec_valid && dec_ready && !q_empty;
        q_flush = redirect_valid;

        case (state_q)
            FETCH_REQ: begin
                if (imem_req && imem_gnt) begin
                    req_pc_d   = fetch_pc_q;
                    fetch_pc_d = fetch_pc_q + 32'd4;
                    state_d    = redirect_valid ? FETCH_DROP : FETCH_WAIT;
                end
            end
            FETCH_WAIT: begin
                if (imem_rvalid) begin
                    state_d = FETCH_REQ;
                end else if (redirect_valid) begin
                    state_d = FETCH_DROP;
                end
            end
            FETCH_DROP: begin
                if (imem_rvalid) begin
                    state_d = FETCH_REQ;
                end
            end
            default: state_d = FETCH_REQ;
        endcase

        // Redirect overrides the sequential advance taken on a same-cycle grant.
        if (redirect_valid) begin
            fetch_pc_d = word_align(redirect_pc);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FETCH_REQ;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: imem responder model, expected {pc, instr} queue, directed + random phases.
module tb_fetch_stage;

    localparam int          QD  = 2;
    localparam logic [31:0] RPC = 32'h0000_0000;
`ifdef FETCH_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        dec_ready = 1'b0;
    logic        dec_valid;
    logic [31:0] dec_pc;
    logic [31:0] dec_instruction;

    always #5 clk = ~clk;

    fetch_stage #(
        .RESET_PC        (RPC),
        .QDEPTH          (QD)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_gnt        (imem_gnt),
        .imem_rvalid     (imem_rvalid),
        .imem_rdata      (imem_rdata),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .dec_ready       (dec_ready),
        .dec_valid       (dec_valid),
        .dec_pc          (dec_pc),
        .dec_instruction (dec_instruction)
    );

    int          n_vec = 0;
    int          n_err = 0;
    logic [63:0] exp_q[$];
    logic [31:0] seen_pc[$];
    logic        pend_vld = 1'b0;
    logic        pend_drop = 1'b0;
    logic [31:0] pend_addr = '0;
    int          pend_cnt = 0;
    int          rsp_dly = 0;
    int          n_grant = 0;
    logic        stall_prev = 1'b0;
    logic [31:0] stall_addr = '0;
    logic        o_req, o_dv;
    logic [31:0] o_addr, o_pc, o_ins;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {~a[15:0], a[31:16] ^ 16'h5A3C};
    endfunction

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    // One clock: drive at negedge, model the memory, sample at negedge+1, score pops.
    task automatic cycle(input logic gnt_en, input logic rdy, input logic redir, input logic [31:0] rpc);
        logic        deliver;
        logic        was_pend;
        logic [63:0] e;
        @(negedge clk);
        dec_ready      = rdy;
        redirect_valid = redir;
        redirect_pc    = rpc;
        if (redir) exp_q.delete();
        deliver = 1'b0;
        if (pend_vld) begin
            if (pend_cnt == 0) deliver = 1'b1;
            else pend_cnt--;
        end
        imem_rvalid = deliver;
        imem_rdata  = deliver ? mem_word(pend_addr) : 32'hDEAD_BEEF;
        if (deliver) begin
            if (!pend_drop && !redir) exp_q.push_back({pend_addr, mem_word(pend_addr)});
            pend_vld = 1'b0;
        end else if (pend_vld && redir) begin
            pend_drop = 1'b1;
        end
        was_pend = pend_vld;
        imem_gnt = gnt_en && imem_req;
        #1;
        o_req  = imem_req;
        o_addr = imem_addr;
        o_dv   = dec_valid;
        o_pc   = dec_pc;
        o_ins  = dec_instruction;
        if (was_pend) chk("one_outstanding", o_req, 1'b0);
        if (stall_prev && rst_n) chk("addr_stable", o_addr, stall_addr);
        stall_prev = rst_n && o_req && !imem_gnt && !redir;
        stall_addr = o_addr;
        if (imem_gnt && o_req) begin
            pend_vld  = 1'b1;
            pend_addr = o_addr;
            pend_cnt  = rsp_dly;
            pend_drop = redir;
            n_grant++;
        end
        if (redir) chk("redir_dec_valid", o_dv, 1'b0);
        if (o_dv && rdy) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_pop", o_dv, 1'b0);
            end else begin
                e = exp_q.pop_front();
                chk("sb_entry", {o_pc, o_ins}, e);
            end
            seen_pc.push_back(o_pc);
        end
    endtask

    task automatic drain();
        int k = 0;
        while ((pend_vld || exp_q.size() != 0) && k < 60) begin
            cycle(1'b0, 1'b1, 1'b0, '0);
            k++;
        end
        if (k >= 60) chk("drain_timeout", exp_q.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int          g0;
        int          p0;
        int          k;
        logic [31:0] a0, a1;

        // Reset state
        repeat (3) begin
            cycle(1'b0, 1'b1, 1'b0, '0);
            chk("rst_req", o_req, 1'b0);
            chk("rst_dec_valid", o_dv, 1'b0);
            chk("rst_dec_pc", o_pc, 32'h0);
            chk("rst_dec_instr", o_ins, 32'h0);
        end
        rst_n = 1'b1;

        // Sequential fetch 0,4,8 with immediate grant and 1-cycle response
        rsp_dly = 0;
        cycle(1'b1, 1'b1, 1'b0, '0);
        chk("first_req", o_req, 1'b1);
        chk("first_addr", o_addr, RPC);
        cycle(1'b1, 1'b1, 1'b0, '0);
        chk("rvalid_cycle_dv", o_dv, BYP);
        cycle(1'b1, 1'b1, 1'b0, '0);
        chk("latency1_dv", o_dv, !BYP);
        k = 0;
        while (seen_pc.size() < 3 && k < 20) begin
            cycle(1'b1, 1'b1, 1'b0, '0);
            k++;
        end
        chk("seq_pc0", seen_pc[0], 32'h0);
        chk("seq_pc1", seen_pc[1], 32'h4);
        chk("seq_pc2", seen_pc[2], 32'h8);
        drain();

        // Backpressure: dec_ready low for 10 cycles
        g0 = n_grant;
        repeat (10) cycle(1'b1, 1'b0, 1'b0, '0);
        chk("bp_grants", n_grant - g0, QD);
        chk("bp_req_low", o_req, 1'b0);
        p0 = seen_pc.size();
        drain();
        chk("bp_drained", seen_pc.size() - p0, QD);

        // Redirect to 0x103 while a request is outstanding
        rsp_dly = 0;
        cycle(1'b1, 1'b0, 1'b0, '0);
        cycle(1'b0, 1'b0, 1'b0, '0);
        rsp_dly = 2;
        cycle(1'b1, 1'b0, 1'b0, '0);
        chk("wait_grant_req", o_req, 1'b1);
        cycle(1'b0, 1'b1, 1'b1, 32'h0000_0103);
        cycle(1'b0, 1'b1, 1'b0, '0);
        chk("post_redir_dv", o_dv, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, '0);
        chk("drop_cycle_req", o_req, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, '0);
        chk("redir_req", o_req, 1'b1);
        chk("redir_addr", o_addr, 32'h0000_0100);
        chk("redir_q_empty", o_dv, 1'b0);

        // Address wrap at the top of the space
        rsp_dly = 0;
        cycle(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);
        cycle(1'b1, 1'b1, 1'b0, '0);
        chk("wrap_addr_hi", o_addr, 32'hFFFF_FFFC);
        cycle(1'b1, 1'b1, 1'b0, '0);
        cycle(1'b1, 1'b1, 1'b0, '0);
        chk("wrap_req", o_req, 1'b1);
        chk("wrap_addr_lo", o_addr, 32'h0000_0000);
        drain();

        // Full occupancy: pop and rvalid in the same cycle
        cycle(1'b1, 1'b0, 1'b0, '0);
        a0 = o_addr;
        cycle(1'b0, 1'b0, 1'b0, '0);
        cycle(1'b1, 1'b0, 1'b0, '0);
        a1 = o_addr;
        cycle(1'b0, 1'b1, 1'b0, '0);
        chk("full_pop_pc", o_pc, a0);
        cycle(1'b0, 1'b0, 1'b0, '0);
        chk("full_keep_dv", o_dv, 1'b1);
        chk("full_keep_pc", o_pc, a1);
        chk("full_keep_req", o_req, 1'b1);
        drain();

        // Random traffic
        repeat (400) begin
            rsp_dly = $urandom_range(0, 2);
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 19) == 0, $urandom);
        end
        drain();

        // Reset asserted with a request outstanding
        rsp_dly = 2;
        cycle(1'b1, 1'b1, 1'b0, '0);
        chk("prereset_req", o_req, 1'b1);
        rst_n = 1'b0;
        pend_drop = 1'b1;
        exp_q.delete();
        repeat (2) begin
            cycle(1'b0, 1'b1, 1'b0, '0);
            chk("midrst_req", o_req, 1'b0);
            chk("midrst_dv", o_dv, 1'b0);
            chk("midrst_pc", o_pc, 32'h0);
        end
        rst_n = 1'b1;
        cycle(1'b0, 1'b1, 1'b0, '0);
        chk("postrst_req", o_req, 1'b1);
        chk("postrst_addr", o_addr, RPC);
        cycle(1'b0, 1'b1, 1'b0, '0);
        chk("stale_rsp_dropped", o_dv, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
